// File: rtl/gpu_write_scheduler.sv
// Round-robin arbiter that turns one native write request at a time into a single AXI-lite write
// (AW+W, then B) on the GPU's write slave port, returning the response to the granted requester.
module gpu_write_scheduler #(
    parameter int N_REQ      = 2,
    parameter int ADDR_WIDTH = 24,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [N_REQ-1:0]                     req,
    input  logic [N_REQ-1:0][ADDR_WIDTH-1:0]     req_addr,
    input  logic [N_REQ-1:0][DATA_WIDTH-1:0]     req_data,
    input  logic [N_REQ-1:0][STRB_WIDTH-1:0]     req_strb,
    output logic [N_REQ-1:0]                     ack,
    output logic [N_REQ-1:0]                     ack_err,
    output logic                                 busy,
    output logic [ADDR_WIDTH-1:0]                awaddr,
    output logic [2:0]                           awprot,
    output logic                                 awvalid,
    input  logic                                 awready,
    output logic [DATA_WIDTH-1:0]                wdata,
    output logic [STRB_WIDTH-1:0]                wstrb,
    output logic                                 wvalid,
    input  logic                                 wready,
    input  logic [1:0]                           bresp,
    input  logic                                 bvalid,
    output logic                                 bready
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, RESP, DONE} state_t;

    state_t                 state, state_next;
    logic [PTR_W-1:0]       ptr, ptr_next;
    logic [PTR_W-1:0]       gnt, gnt_next;
    logic [PTR_W-1:0]       cand_idx;
    logic [ADDR_WIDTH-1:0]  awaddr_next;
    logic [DATA_WIDTH-1:0]  wdata_next;
    logic [STRB_WIDTH-1:0]  wstrb_next;
    logic                   awvalid_next, wvalid_next, bready_next, busy_next;
    logic [N_REQ-1:0]       ack_next, ack_err_next;
    logic                   found;
    int                     cand;

    assign awprot = 3'b000;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            ptr     <= '0;
            gnt     <= '0;
            awaddr  <= '0;
            wdata   <= '0;
            wstrb   <= '0;
            awvalid <= 1'b0;
            wvalid  <= 1'b0;
            bready  <= 1'b0;
            busy    <= 1'b0;
            ack     <= '0;
            ack_err <= '0;
        end else begin
            state   <= state_next;
            ptr     <= ptr_next;
            gnt     <= gnt_next;
            awaddr  <= awaddr_next;
            wdata   <= wdata_next;
            wstrb   <= wstrb_next;
            awvalid <= awvalid_next;
            wvalid  <= wvalid_next;
            bready  <= bready_next;
            busy    <= busy_next;
            ack     <= ack_next;
            ack_err <= ack_err_next;
        end
    end

    always_comb begin
        state_next   = state;
        ptr_next     = ptr;
        gnt_next     = gnt;
        awaddr_next  = awaddr;
        wdata_next   = wdata;
        wstrb_next   = wstrb;
        awvalid_next = awvalid;
        wvalid_next  = wvalid;
        bready_next  = bready;
        ack_next     = '0;
        ack_err_next = '0;
        found        = 1'b0;
        cand         = 0;
        cand_idx     = '0;

        case (state)
            IDLE: begin
                // Scan starts at ptr so the last-served requester goes to the back of the line
                for (int i = 0; i < N_REQ; i++) begin
                    cand = int'(ptr) + i;
                    if (cand >= N_REQ) cand = cand - N_REQ;
                    cand_idx = PTR_W'(cand);
                    if (!found && req[cand_idx]) begin
                        found       = 1'b1;
                        gnt_next    = cand_idx;
                        awaddr_next = req_addr[cand_idx];
                        wdata_next  = req_data[cand_idx];
                        wstrb_next  = req_strb[cand_idx];
                    end
                end
                if (found) begin
                    state_next   = ISSUE;
                    awvalid_next = 1'b1;
                    wvalid_next  = 1'b1;
                end
            end
            ISSUE: begin
                awvalid_next = awvalid && !awready;
                wvalid_next  = wvalid && !wready;
                if (!awvalid_next && !wvalid_next) begin
                    state_next  = RESP;
                    bready_next = 1'b1;
                end
            end
            RESP: begin
                if (bvalid) begin
                    bready_next            = 1'b0;
                    state_next             = DONE;
                    ack_next[gnt]          = 1'b1;
                    ack_err_next[gnt]      = (bresp != 2'b00);
                end
            end
            DONE: begin
                state_next = IDLE;
                ptr_next   = (gnt == PTR_W'(N_REQ - 1)) ? '0 : gnt + PTR_W'(1);
            end
            default: state_next = IDLE;
        endcase

        busy_next = (state_next != IDLE);
    end

endmodule

// File: tb/tb_gpu_write_scheduler.sv
// Self-checking bench for gpu_write_scheduler: a cycle-stepped AXI-lite slave with programmable
// delays plus a round-robin/latency reference model computed from the arbitration rules.
module tb_gpu_write_scheduler;

    localparam int N  = 2;
    localparam int AW = 24;
    localparam int DW = 32;
    localparam int SW = 4;

    logic                   clk;
    logic                   rst;
    logic [N-1:0]           req;
    logic [N-1:0][AW-1:0]   req_addr;
    logic [N-1:0][DW-1:0]   req_data;
    logic [N-1:0][SW-1:0]   req_strb;
    logic [N-1:0]           ack;
    logic [N-1:0]           ack_err;
    logic                   busy;
    logic [AW-1:0]          awaddr;
    logic [2:0]             awprot;
    logic                   awvalid;
    logic                   awready;
    logic [DW-1:0]          wdata;
    logic [SW-1:0]          wstrb;
    logic                   wvalid;
    logic                   wready;
    logic [1:0]             bresp;
    logic                   bvalid;
    logic                   bready;

    int checks    = 0;
    int failures  = 0;
    int model_ptr = 0;

    typedef struct {
        int           lat;
        logic [N-1:0] ack_v;
        logic [N-1:0] err_v;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [SW-1:0] strb;
        int           aw_cnt;
        int           w_cnt;
        int           aw_cyc;
        int           bready_first;
        int           bready_cnt;
        logic         stable;
        logic         busy_ok;
        logic         ack_once;
    } res_t;

    gpu_write_scheduler #(
        .N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_data(req_data),
        .req_strb(req_strb), .ack(ack), .ack_err(ack_err), .busy(busy),
        .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    function automatic int rr_pick(input int p, input logic [N-1:0] r);
        for (int i = 0; i < N; i++)
            if (r[(p + i) % N]) return (p + i) % N;
        return -1;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Cycle 0 is the current (IDLE) cycle; returns one cycle after the ack, with the DUT back in IDLE
    task automatic do_write(input logic [N-1:0] set_bits, input logic [N-1:0] late_bits,
                            input int aw_dly, input int w_dly, input int b_dly,
                            input logic [1:0] resp, output res_t r);
        int aw_seen, w_seen, b_seen;
        r = '{lat: -1, ack_v: '0, err_v: '0, addr: '0, data: '0, strb: '0, aw_cnt: 0, w_cnt: 0,
              aw_cyc: -1, bready_first: -1, bready_cnt: 0, stable: 1'b1, busy_ok: 1'b1, ack_once: 1'b1};
        aw_seen = 0; w_seen = 0; b_seen = 0;
        req = req | set_bits;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        for (int cyc = 1; cyc <= 300 && r.lat < 0; cyc++) begin
            @(posedge clk); #1;
            if (cyc == 2) req = req | late_bits;
            if (!busy) r.busy_ok = 1'b0;
            if (ack != '0) begin
                r.lat      = cyc;
                r.ack_v    = ack;
                r.err_v    = ack_err;
                r.ack_once = ($countones(ack) == 1);
                req        = req & ~ack;
            end
            awready = 1'b0;
            if (awvalid) begin
                if (aw_seen == 0) r.addr = awaddr;
                else if (awaddr !== r.addr) r.stable = 1'b0;
                if (aw_seen >= aw_dly) begin awready = 1'b1; r.aw_cyc = cyc; end
                aw_seen++;
            end
            wready = 1'b0;
            if (wvalid) begin
                if (w_seen == 0) begin r.data = wdata; r.strb = wstrb; end
                else if (wdata !== r.data || wstrb !== r.strb) r.stable = 1'b0;
                if (w_seen >= w_dly) wready = 1'b1;
                w_seen++;
            end
            bvalid = 1'b0;
            if (bready) begin
                if (r.bready_first < 0) r.bready_first = cyc;
                r.bready_cnt++;
                if (b_seen >= b_dly) begin bvalid = 1'b1; bresp = resp; end
                b_seen++;
            end
        end
        r.aw_cnt = aw_seen;
        r.w_cnt  = w_seen;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        if (r.lat < 0) begin
            failures++;
            $display("[TB] FAIL timeout: no ack within 300 cycles");
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; req = '0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        req_addr = '0; req_data = '0; req_strb = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if ({awvalid, wvalid, bready, busy} !== 4'b0) begin failures++;
            $display("[TB] FAIL reset_ctrl: got %b expected 0000", {awvalid, wvalid, bready, busy}); end
        checks++; if ({ack, ack_err} !== '0) begin failures++;
            $display("[TB] FAIL reset_ack: got %b expected 0", {ack, ack_err}); end
        checks++; if (awaddr !== '0) begin failures++;
            $display("[TB] FAIL reset_awaddr: got %h expected 0", awaddr); end
        checks++; if (wdata !== '0 || wstrb !== '0) begin failures++;
            $display("[TB] FAIL reset_wdata: got %h/%h expected 0/0", wdata, wstrb); end
        checks++; if (awprot !== 3'b000) begin failures++;
            $display("[TB] FAIL reset_awprot: got %b expected 000", awprot); end
        rst = 1'b1;
        model_ptr = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_single_write();
        res_t r;
        int g;
        req_addr[0] = 24'h000010; req_data[0] = 32'h00000F00; req_strb[0] = 4'hF;
        g = rr_pick(model_ptr, 2'b01);
        do_write(2'b01, '0, 0, 0, 0, 2'b00, r);
        checks++; if (r.lat !== 3) begin failures++;
            $display("[TB] FAIL single_latency: got %0d expected 3", r.lat); end
        checks++; if (r.ack_v !== N'(1 << g)) begin failures++;
            $display("[TB] FAIL single_ack: got %b expected %b", r.ack_v, N'(1 << g)); end
        checks++; if (r.err_v !== '0) begin failures++;
            $display("[TB] FAIL single_err: got %b expected 0", r.err_v); end
        checks++; if (r.addr !== 24'h000010) begin failures++;
            $display("[TB] FAIL single_awaddr: got %h expected 000010", r.addr); end
        checks++; if (r.data !== 32'h00000F00 || r.strb !== 4'hF) begin failures++;
            $display("[TB] FAIL single_wdata: got %h/%h expected 00000f00/f", r.data, r.strb); end
        checks++; if (!r.busy_ok) begin failures++;
            $display("[TB] FAIL single_busy: busy dropped during transaction, expected 1"); end
        model_ptr = (g + 1) % N;
    endtask

    task automatic test_round_robin();
        res_t r;
        int g;
        logic [N-1:0] pend;
        req_addr[0] = 24'h00AA00; req_data[0] = 32'h11110000; req_strb[0] = 4'h3;
        req_addr[1] = 24'h00BB00; req_data[1] = 32'h22220000; req_strb[1] = 4'hC;
        do_write(2'b01, '0, 0, 0, 0, 2'b00, r);
        model_ptr = 1;
        pend = 2'b11;
        for (int k = 0; k < 2; k++) begin
            g = rr_pick(model_ptr, pend);
            do_write((k == 0) ? 2'b11 : 2'b00, '0, 0, 0, 0, 2'b00, r);
            checks++; if (r.ack_v !== N'(1 << g) || !r.ack_once) begin failures++;
                $display("[TB] FAIL rr_ack_%0d: got %b expected %b", k, r.ack_v, N'(1 << g)); end
            checks++; if (r.addr !== req_addr[g] || r.data !== req_data[g] || r.strb !== req_strb[g]) begin
                failures++;
                $display("[TB] FAIL rr_payload_%0d: got %h/%h/%h expected %h/%h/%h", k, r.addr, r.data,
                         r.strb, req_addr[g], req_data[g], req_strb[g]); end
            pend[g] = 1'b0;
            model_ptr = (g + 1) % N;
        end
    endtask

    task automatic test_aw_delay();
        res_t r;
        int g;
        req_addr[0] = 24'h123456; req_data[0] = 32'hCAFEF00D; req_strb[0] = 4'h5;
        g = rr_pick(model_ptr, 2'b01);
        do_write(2'b01, '0, 3, 0, 0, 2'b00, r);
        checks++; if (r.w_cnt !== 1) begin failures++;
            $display("[TB] FAIL awdly_wvalid_cycles: got %0d expected 1", r.w_cnt); end
        checks++; if (r.aw_cnt !== 4) begin failures++;
            $display("[TB] FAIL awdly_awvalid_cycles: got %0d expected 4", r.aw_cnt); end
        checks++; if (!r.stable || r.addr !== 24'h123456) begin failures++;
            $display("[TB] FAIL awdly_awaddr: got %h stable=%b expected 123456 stable=1", r.addr, r.stable); end
        checks++; if (r.bready_first !== r.aw_cyc + 1) begin failures++;
            $display("[TB] FAIL awdly_bready: got cycle %0d expected %0d", r.bready_first, r.aw_cyc + 1); end
        checks++; if (r.lat !== 6) begin failures++;
            $display("[TB] FAIL awdly_latency: got %0d expected 6", r.lat); end
        model_ptr = (g + 1) % N;
    endtask

    task automatic test_error_resp();
        res_t r;
        int g;
        g = rr_pick(model_ptr, 2'b10);
        do_write(2'b10, '0, 0, 0, 0, 2'b10, r);
        checks++; if (r.ack_v !== N'(1 << g) || r.err_v !== N'(1 << g)) begin failures++;
            $display("[TB] FAIL err_slverr: got ack=%b err=%b expected %b/%b", r.ack_v, r.err_v,
                     N'(1 << g), N'(1 << g)); end
        model_ptr = (g + 1) % N;
        g = rr_pick(model_ptr, 2'b10);
        do_write(2'b10, '0, 0, 0, 0, 2'b00, r);
        checks++; if (r.ack_v !== N'(1 << g) || r.err_v !== '0) begin failures++;
            $display("[TB] FAIL err_okay: got ack=%b err=%b expected %b/00", r.ack_v, r.err_v, N'(1 << g)); end
        model_ptr = (g + 1) % N;
    endtask

    task automatic test_reset_mid();
        res_t r;
        int n;
        req = 2'b10; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
        n = 0;
        while (!awvalid && n < 10) begin @(posedge clk); #1; n++; end
        checks++; if (awvalid !== 1'b1) begin failures++;
            $display("[TB] FAIL rstmid_issue: awvalid got %b expected 1", awvalid); end
        #5 rst = 1'b0;
        #1;
        checks++; if ({awvalid, wvalid, bready, busy, ack} !== '0) begin failures++;
            $display("[TB] FAIL rstmid_drop: got %b expected 0", {awvalid, wvalid, bready, busy, ack}); end
        repeat (2) @(posedge clk);
        #5 rst = 1'b1;
        model_ptr = 0;
        do_write('0, '0, 0, 0, 0, 2'b00, r);
        checks++; if (r.ack_v !== N'(1 << rr_pick(0, 2'b10)) || r.lat !== 3) begin failures++;
            $display("[TB] FAIL rstmid_reissue: got ack=%b lat=%0d expected 10/3", r.ack_v, r.lat); end
        model_ptr = (rr_pick(0, 2'b10) + 1) % N;
    endtask

    task automatic test_bresp_stall();
        res_t r;
        int g;
        g = rr_pick(model_ptr, 2'b10);
        do_write(2'b10, 2'b01, 0, 0, 10, 2'b00, r);
        checks++; if (r.bready_cnt !== 11 || r.bready_first !== 2) begin failures++;
            $display("[TB] FAIL stall_bready: got %0d cycles from %0d expected 11 from 2",
                     r.bready_cnt, r.bready_first); end
        checks++; if (!r.busy_ok) begin failures++;
            $display("[TB] FAIL stall_busy: busy dropped, expected 1 throughout"); end
        checks++; if (r.ack_v !== N'(1 << g) || r.lat !== 13) begin failures++;
            $display("[TB] FAIL stall_ack: got %b at %0d expected %b at 13", r.ack_v, r.lat, N'(1 << g)); end
        model_ptr = (g + 1) % N;
        g = rr_pick(model_ptr, 2'b01);
        do_write('0, '0, 0, 0, 0, 2'b00, r);
        checks++; if (r.ack_v !== N'(1 << g) || r.lat !== 3) begin failures++;
            $display("[TB] FAIL stall_pending: got %b at %0d expected %b at 3", r.ack_v, r.lat, N'(1 << g)); end
        model_ptr = (g + 1) % N;
    endtask

    task automatic test_random();
        res_t r;
        int g, awd, wd, bd, exp_lat;
        logic [N-1:0] nb;
        logic [1:0] resp;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        logic [SW-1:0] es;
        for (int it = 0; it < 24; it++) begin
            for (int k = 0; k < N; k++) begin
                req_addr[k] = AW'($urandom);
                req_data[k] = $urandom;
                req_strb[k] = SW'($urandom);
            end
            nb = N'($urandom_range(0, 3));
            if ((req | nb) == '0) nb = 2'b01;
            awd = $urandom_range(0, 3); wd = $urandom_range(0, 3); bd = $urandom_range(0, 3);
            resp = 2'($urandom_range(0, 3));
            g = rr_pick(model_ptr, req | nb);
            ea = req_addr[g]; ed = req_data[g]; es = req_strb[g];
            exp_lat = 3 + max2(awd, wd) + bd;
            do_write(nb, '0, awd, wd, bd, resp, r);
            checks++; if (r.ack_v !== N'(1 << g) || !r.ack_once) begin failures++;
                $display("[TB] FAIL rand_grant_%0d: got %b expected %b", it, r.ack_v, N'(1 << g)); end
            checks++; if (r.err_v !== ((resp != 2'b00) ? N'(1 << g) : N'(0))) begin failures++;
                $display("[TB] FAIL rand_err_%0d: got %b for bresp %b", it, r.err_v, resp); end
            checks++; if (r.lat !== exp_lat) begin failures++;
                $display("[TB] FAIL rand_latency_%0d: got %0d expected %0d", it, r.lat, exp_lat); end
            checks++; if (r.addr !== ea || r.data !== ed || r.strb !== es || !r.stable) begin failures++;
                $display("[TB] FAIL rand_payload_%0d: got %h/%h/%h expected %h/%h/%h", it, r.addr, r.data,
                         r.strb, ea, ed, es); end
            model_ptr = (g + 1) % N;
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_round_robin();
        test_aw_delay();
        test_error_resp();
        test_reset_mid();
        test_bresp_stall();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
